// File: rtl/video_out_pkg.sv
// Shared types and sizing helpers for the video output stage.
// The optional test-pattern source is enabled with VIDEO_TEST_PATTERN_EN.
package video_out_pkg;

    typedef enum logic [1:0] {
        VBLANK = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2
    } state_t;

    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned FCNT_W    = 16;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : 32'($clog2(max_val + 32'd1));
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Column, line and blanking counters with terminal-count flags, stepped by the FSM state.
// Exposes col/line only when VIDEO_TEST_PATTERN_EN is defined.
module video_timing_cnt
    import video_out_pkg::*;
#(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned HEIGHT  = 480,
    parameter int unsigned H_BLANK = 160,
    parameter int unsigned V_BLANK = 32000
) (
    input  logic   clk,
    input  logic   nRST,
    input  logic   pix_en,
    input  state_t state,
    output logic   col_last_c,
    output logic   line_last_c,
    output logic   h_last_c,
    output logic   v_done_c
`ifdef VIDEO_TEST_PATTERN_EN
    ,
    output logic [cnt_w(WIDTH-1)-1:0]  col,
    output logic [cnt_w(HEIGHT-1)-1:0] line
`endif
);

    localparam int unsigned COL_W  = cnt_w(WIDTH - 1);
    localparam int unsigned LINE_W = cnt_w(HEIGHT - 1);
    localparam int unsigned H_W    = cnt_w(H_BLANK - 1);
    localparam int unsigned V_W    = cnt_w(V_BLANK);

    logic [COL_W-1:0]  col_q;
    logic [LINE_W-1:0] line_q;
    logic [H_W-1:0]    hcnt_q;
    logic [V_W-1:0]    vcnt_q;

    assign col_last_c  = (col_q == COL_W'(WIDTH - 1));
    assign line_last_c = (line_q == LINE_W'(HEIGHT - 1));
    assign h_last_c    = (hcnt_q == H_W'(H_BLANK - 1));
    assign v_done_c    = (vcnt_q == V_W'(V_BLANK));

`ifdef VIDEO_TEST_PATTERN_EN
    assign col  = col_q;
    assign line = line_q;
`endif

    // Counters not owned by the current state are parked at zero so each state starts clean.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            col_q  <= '0;
            line_q <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (pix_en) begin
            unique case (state)
                VBLANK: begin
                    col_q  <= '0;
                    line_q <= '0;
                    hcnt_q <= '0;
                    if (!v_done_c) vcnt_q <= vcnt_q + V_W'(1);
                end
                ACTIVE: begin
                    vcnt_q <= '0;
                    hcnt_q <= '0;
                    col_q  <= col_last_c ? '0 : col_q + COL_W'(1);
                    if (col_last_c) line_q <= line_last_c ? '0 : line_q + LINE_W'(1);
                end
                HBLANK: begin
                    hcnt_q <= h_last_c ? '0 : hcnt_q + H_W'(1);
                end
                default: begin
                    col_q  <= '0;
                    line_q <= '0;
                    hcnt_q <= '0;
                    vcnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/video_stream_gen.sv
// Pops pixels from a show-ahead fifo and emits a frame_valid/line_valid pixel stream.
// Define VIDEO_TEST_PATTERN_EN to add the test_mode input and (col+line) pattern source.
module video_stream_gen
    import video_out_pkg::*;
#(
    parameter int unsigned      PIX_W         = PIX_W_DEF,
    parameter int unsigned      WIDTH         = 640,
    parameter int unsigned      HEIGHT        = 480,
    parameter int unsigned      H_BLANK       = 160,
    parameter int unsigned      V_BLANK       = 32000,
    parameter logic [PIX_W-1:0] UNDERFLOW_PIX = '0
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              pix_en,
    output logic              r_ack,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              nb_pack_available,
`ifdef VIDEO_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [PIX_W-1:0]  pixel_out,
    output logic              frame_valid,
    output logic              line_valid,
    output logic              underflow,
    output logic [FCNT_W-1:0] frame_cnt
);

    state_t state_q, state_d;
    logic   col_last_c, line_last_c, h_last_c, v_done_c;
    logic   start_ok_c;
    logic   tm_q;
    logic [PIX_W-1:0] pat_pix_c;

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int unsigned COL_W  = cnt_w(WIDTH - 1);
    localparam int unsigned LINE_W = cnt_w(HEIGHT - 1);

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;

    assign start_ok_c = nb_pack_available | test_mode;
    assign pat_pix_c  = PIX_W'(32'(col) + 32'(line));

    // Pattern mode is latched as the frame begins and held until the next VBLANK exit.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            tm_q <= 1'b0;
        end else if (pix_en && state_q == VBLANK && v_done_c && start_ok_c) begin
            tm_q <= test_mode;
        end
    end
`else
    assign start_ok_c = nb_pack_available;
    assign tm_q       = 1'b0;
    assign pat_pix_c  = '0;
`endif

    video_timing_cnt #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .H_BLANK (H_BLANK),
        .V_BLANK (V_BLANK)
    ) u_timing (
        .clk         (clk),
        .nRST        (nRST),
        .pix_en      (pix_en),
        .state       (state_q),
        .col_last_c  (col_last_c),
        .line_last_c (line_last_c),
        .h_last_c    (h_last_c),
        .v_done_c    (v_done_c)
`ifdef VIDEO_TEST_PATTERN_EN
        ,
        .col         (col),
        .line        (line)
`endif
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state_q <= VBLANK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (pix_en) begin
            unique case (state_q)
                VBLANK:  if (v_done_c && start_ok_c) state_d = ACTIVE;
                ACTIVE:  if (col_last_c) state_d = line_last_c ? VBLANK : HBLANK;
                HBLANK:  if (h_last_c) state_d = ACTIVE;
                default: state_d = VBLANK;
            endcase
        end
    end

    // A starved tick still occupies its pixel slot, so pop only when data is really there.
    assign r_ack = (state_q == ACTIVE) & pix_en & nb_pack_available & ~tm_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            pixel_out   <= '0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            underflow   <= 1'b0;
            frame_cnt   <= '0;
        end else if (pix_en) begin
            unique case (state_q)
                ACTIVE: begin
                    line_valid  <= 1'b1;
                    frame_valid <= 1'b1;
                    if (tm_q) begin
                        pixel_out <= pat_pix_c;
                    end else if (nb_pack_available) begin
                        pixel_out <= pixel_in;
                    end else begin
                        pixel_out <= UNDERFLOW_PIX;
                        underflow <= 1'b1;
                    end
                    if (col_last_c && line_last_c) frame_cnt <= frame_cnt + FCNT_W'(1);
                end
                HBLANK: begin
                    line_valid  <= 1'b0;
                    frame_valid <= 1'b1;
                end
                default: begin
                    line_valid  <= 1'b0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// Scoreboard bench for video_stream_gen on a 4x3 frame with short blanking.
// Test-pattern checks are compiled in when VIDEO_TEST_PATTERN_EN is defined.
module tb_video_stream_gen;

    localparam int PW  = 8;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int HB  = 2;
    localparam int VB  = 5;
    localparam logic [PW-1:0] UFP = 8'hEE;

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          pix_en = 1'b0;
    logic          nb_pack_available = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic          r_ack;
    logic [PW-1:0] pixel_out;
    logic          frame_valid;
    logic          line_valid;
    logic          underflow;
    logic [15:0]   frame_cnt;
`ifdef VIDEO_TEST_PATTERN_EN
    logic          test_mode = 1'b0;
`endif

    // One expected tick: stimulus hints plus the outputs required after it.
    typedef struct {
        logic          starve;
        logic          tp;
        logic          ack;
        logic          lv;
        logic          fv;
        logic [PW-1:0] pix;
        logic          uf;
        logic [15:0]   fc;
    } rec_t;

    rec_t          exp_q[$];
    logic [PW-1:0] fifo_q[$];
    rec_t          hold;
    int            errors = 0;
    int            checks = 0;
    logic [PW-1:0] g_pix;
    logic [PW-1:0] g_val;
    logic          g_uf;
    logic [15:0]   g_fc;

    always #5 clk = ~clk;

    video_stream_gen #(
        .PIX_W         (PW),
        .WIDTH         (W),
        .HEIGHT        (H),
        .H_BLANK       (HB),
        .V_BLANK       (VB),
        .UNDERFLOW_PIX (UFP)
    ) dut (
        .clk               (clk),
        .nRST              (nRST),
        .pix_en            (pix_en),
        .r_ack             (r_ack),
        .pixel_in          (pixel_in),
        .nb_pack_available (nb_pack_available),
`ifdef VIDEO_TEST_PATTERN_EN
        .test_mode         (test_mode),
`endif
        .pixel_out         (pixel_out),
        .frame_valid       (frame_valid),
        .line_valid        (line_valid),
        .underflow         (underflow),
        .frame_cnt         (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void put(input logic st, input logic tp, input logic ack,
                                input logic lv, input logic fv);
        rec_t r;
        r.starve = st;
        r.tp     = tp;
        r.ack    = ack;
        r.lv     = lv;
        r.fv     = fv;
        r.pix    = g_pix;
        r.uf     = g_uf;
        r.fc     = g_fc;
        exp_q.push_back(r);
    endfunction

    function automatic void preload(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(PW'(first + i));
        g_val = PW'(first);
    endfunction

    // Expected ticks for one frame: vblank wait, then H lines of W pixels with hblank between.
    function automatic void push_frame(input int nst, input int s_lo, input int s_hi, input logic tp);
        int idx;
        for (int i = 0; i <= VB + nst; i++) put(tp || (i < VB + nst), tp, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < H; l++) begin
            for (int c = 0; c < W; c++) begin
                idx = l * W + c + 1;
                if (l == H - 1 && c == W - 1) g_fc = g_fc + 16'd1;
                if (tp) begin
                    g_pix = PW'(c + l);
                    put(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
                end else if (idx >= s_lo && idx <= s_hi) begin
                    g_pix = UFP;
                    g_uf  = 1'b1;
                    put(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
                end else begin
                    g_pix = g_val;
                    g_val = g_val + PW'(1);
                    put(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                end
            end
            if (l < H - 1) begin
                for (int b = 0; b < HB; b++) put(1'b1, tp, 1'b0, 1'b0, 1'b1);
            end
        end
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check_outputs(input string pfx, input rec_t e);
        chk({pfx, "_line_valid"}, 32'(line_valid), 32'(e.lv));
        chk({pfx, "_frame_valid"}, 32'(frame_valid), 32'(e.fv));
        chk({pfx, "_pixel_out"}, 32'(pixel_out), 32'(e.pix));
        chk({pfx, "_underflow"}, 32'(underflow), 32'(e.uf));
        chk({pfx, "_frame_cnt"}, 32'(frame_cnt), 32'(e.fc));
    endtask

    // Assert reset, require all-zero outputs, clear the models, then release.
    task automatic do_reset();
        @(negedge clk);
        nRST = 1'b0;
        pix_en = 1'b0;
        nb_pack_available = 1'b0;
        #2;
        g_pix = '0;
        g_uf  = 1'b0;
        g_fc  = '0;
        g_val = '0;
        exp_q.delete();
        fifo_q.delete();
        hold.starve = 1'b1;
        hold.tp     = 1'b0;
        hold.ack    = 1'b0;
        hold.lv     = 1'b0;
        hold.fv     = 1'b0;
        hold.pix    = '0;
        hold.uf     = 1'b0;
        hold.fc     = '0;
        check_outputs("reset", hold);
        chk("reset_r_ack", 32'(r_ack), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
    endtask

    // One clk starting at a negedge; fifo pops follow the observed r_ack.
    task automatic cycle(input logic en, input rec_t e);
        logic ack;
        pix_en = en;
        nb_pack_available = !e.starve && (fifo_q.size() != 0);
        pixel_in = (fifo_q.size() != 0) ? fifo_q[0] : '0;
`ifdef VIDEO_TEST_PATTERN_EN
        test_mode = e.tp;
`endif
        #1;
        ack = r_ack;
        chk(en ? "r_ack" : "r_ack_idle", 32'(ack), en ? 32'(e.ack) : 32'd0);
        @(posedge clk);
        if (ack === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(negedge clk);
        check_outputs(en ? "tick" : "idle", e);
    endtask

    task automatic run(input int n, input int gap);
        rec_t e;
        for (int k = 0; k < n && exp_q.size() != 0; k++) begin
            e = exp_q.pop_front();
            for (int g = 0; g < gap; g++) cycle(1'b0, hold);
            cycle(1'b1, e);
            hold = e;
        end
    endtask

    initial begin
        do_reset();

        // Full-rate frame from a preloaded fifo.
        preload(1, 12);
        push_frame(0, 1, 0, 1'b0);
        push_idle(3);
        run(1000, 0);
        chk("t1_fifo_left", 32'(fifo_q.size()), 32'd0);

        // Pixel enable on every third clk.
        do_reset();
        preload(1, 12);
        push_frame(0, 1, 0, 1'b0);
        push_idle(2);
        run(1000, 2);
        chk("t2_fifo_left", 32'(fifo_q.size()), 32'd0);

        // Fifo starved for active pixels 6 and 7.
        do_reset();
        preload(1, 12);
        push_frame(0, 6, 7, 1'b0);
        push_idle(2);
        run(1000, 0);
        chk("t3_fifo_left", 32'(fifo_q.size()), 32'd2);

        // No data for 20 ticks past vblank expiry.
        do_reset();
        preload(1, 12);
        push_frame(20, 1, 0, 1'b0);
        push_idle(2);
        run(1000, 0);
        chk("t4_fifo_left", 32'(fifo_q.size()), 32'd0);

        // Asynchronous reset in the middle of line 2, then a clean frame.
        do_reset();
        preload(1, 12);
        push_frame(0, 1, 0, 1'b0);
        run(VB + 1 + W + HB + 2, 0);
        chk("t5_pre_line_valid", 32'(line_valid), 32'd1);
        #3;
        nRST = 1'b0;
        #1;
        chk("t5_async_pixel_out", 32'(pixel_out), 32'd0);
        chk("t5_async_line_valid", 32'(line_valid), 32'd0);
        chk("t5_async_frame_valid", 32'(frame_valid), 32'd0);
        chk("t5_async_r_ack", 32'(r_ack), 32'd0);
        do_reset();
        preload(1, 12);
        push_frame(0, 1, 0, 1'b0);
        push_idle(2);
        run(1000, 0);
        chk("t5_fifo_left", 32'(fifo_q.size()), 32'd0);

`ifdef VIDEO_TEST_PATTERN_EN
        // Pattern frame: starts with an empty fifo, never pops even once data appears.
        do_reset();
        push_frame(0, 1, 0, 1'b1);
        push_idle(2);
        preload(100, 4);
        run(1000, 0);
        chk("t6_fifo_left", 32'(fifo_q.size()), 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
